// File: rtl/uart_rx.sv
// uart_rx: 8-N-1 serial receiver with mid-bit sampling and a one-entry valid/ready output buffer.
// Optional macro UART_RX_PARITY_EN switches to 8-E-1 framing and adds the parity_err pulse.
module uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t        state;
  logic          sync1;
  logic          rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          cnt_last;
  logic          par_ok;
  logic          byte_done;

`ifdef UART_RX_PARITY_EN
  logic          par_bit;
  assign par_ok = (par_bit == ^shreg);
`else
  assign par_ok = 1'b1;
`endif

  assign cnt_last  = (cnt == CNT_LAST);
  assign byte_done = (state == STOP) && cnt_last && rxs && par_ok;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Handshake: a byte transfers on any rising CLK edge where rx_valid && rx_ready;
  // rx_data holds steady while rx_valid is high, and a byte finishing into a full,
  // unaccepted buffer is dropped with an overrun pulse.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      rxs       <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      sync1     <= rx_pin;
      rxs       <= sync1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      cnt <= cnt_last ? '0 : cnt + 1'b1;

      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CNT_MID) begin
            cnt <= '0;
            if (!rxs) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (cnt_last) begin
            shreg   <= {rxs, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
              cnt <= '0;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_last) begin
            par_bit <= rxs;
            state   <= STOP;
            cnt     <= '0;
          end
        end
`endif
        STOP: begin
          if (cnt_last) begin
            cnt <= '0;
            if (!rxs) begin
              // Framing error wins over any parity mismatch.
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end else begin
              state <= IDLE;
`ifdef UART_RX_PARITY_EN
              parity_err <= !par_ok;
`endif
            end
          end
        end
        WAIT_IDLE: begin
          // A held-low line (break) must not decode as a stream of zero bytes.
          if (rxs) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      if (byte_done) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
